csa_accum_ctrl: RTL and testbench

Sequential multi-operand accumulator controller built around one 3:2 carry-save compressor slice. It accepts a programmed number of unsigned operands over a valid/ready stream and folds each operand into a redundant (sum, carry) state in one cycle, with no carry propagation. After the last operand it performs a single carry-propagate resolve and presents the result over a valid/ready output. It sits ahead of the dot-product normalisation stage as a reusable reduction sequencer.

---
 rtl/csa_accum_ctrl.sv | 122 ++++++++++++
 tb/tb_csa_accum_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl
// Multi-operand accumulator sequencer built around a single 3:2 carry-save
// compressor slice. Operands are folded into a redundant (sum, carry) pair
// with no carry propagation. One carry-propagate add then resolves the pair,
// and the result is offered on a valid/ready output.
//
// Ports:
//   clk_i        clock, rising-edge active
//   rst_ni       asynchronous active-low reset
//   start_i      job start, sampled only in IDLE
//   num_ops_i    operand count for the job, sampled with start_i
//   op_valid_i   operand valid
//   op_ready_o   operand ready (high only while accumulating)
//   op_data_i    operand value, unsigned, zero-extended
//   res_valid_o  result valid
//   res_ready_i  result accepted
//   res_data_o   resolved sum, modulo 2^ACC_WIDTH
//   busy_o       high in any state except IDLE

module csa_accum_ctrl #(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int MAX_OPS   = 8,
  parameter int CNT_W     = $clog2(MAX_OPS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     num_ops_i,
  input  logic                 op_valid_i,
  output logic                 op_ready_o,
  input  logic [IN_WIDTH-1:0]  op_data_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [ACC_WIDTH-1:0] res_data_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OPS);

  state_t               state_q;
  logic [ACC_WIDTH-1:0] sum_q;
  logic [ACC_WIDTH-1:0] carry_q;
  logic [ACC_WIDTH-1:0] res_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [ACC_WIDTH-1:0] op_ext;
  logic [ACC_WIDTH-1:0] csa_sum;
  logic [ACC_WIDTH-1:0] csa_carry;
  logic [CNT_W-1:0]     load_cnt;
  logic                 op_hs;

  // Carry-save slice: the majority vector is shifted up one place. Shifting
  // the full-width vector drops the top carry, which gives the modulo wrap.
  always_comb begin
    op_ext    = ACC_WIDTH'(op_data_i);
    csa_sum   = sum_q ^ carry_q ^ op_ext;
    csa_carry = ((sum_q & carry_q) | (sum_q & op_ext) | (carry_q & op_ext)) << 1;
    load_cnt  = (num_ops_i > MAX_CNT) ? MAX_CNT : num_ops_i;
  end

  // The handshake outputs depend on state alone, so ready never waits on valid.
  // They also cannot be high together.
  assign op_ready_o  = (state_q == ACCUM);
  assign res_valid_o = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign res_data_o  = res_q;
  assign op_hs       = op_valid_i & op_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= load_cnt;
            state_q <= (load_cnt == '0) ? RESOLVE : ACCUM;
          end
        end

        ACCUM: begin
          if (op_hs) begin
            sum_q   <= csa_sum;
            carry_q <= csa_carry;
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_q <= RESOLVE;
            end
          end
        end

        RESOLVE: begin
          res_q   <= sum_q + carry_q;
          state_q <= DONE;
        end

        DONE: begin
          if (res_ready_i) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
module tb_csa_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  num_ops;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_data;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;
  logic        busy;

  logic        start16;
  logic [3:0]  num_ops16;
  logic        op_valid16;
  logic        op_ready16;
  logic [15:0] op_data16;
  logic        res_valid16;
  logic        res_ready16;
  logic [15:0] res_data16;
  logic        busy16;

  int checks = 0;
  int passed = 0;
  logic [23:0] exp_q[$];

  always #5 clk = ~clk;

  csa_accum_ctrl u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_ops_i(num_ops),
    .op_valid_i(op_valid), .op_ready_o(op_ready), .op_data_i(op_data),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .busy_o(busy)
  );

  csa_accum_ctrl #(.ACC_WIDTH(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .num_ops_i(num_ops16),
    .op_valid_i(op_valid16), .op_ready_o(op_ready16), .op_data_i(op_data16),
    .res_valid_o(res_valid16), .res_ready_i(res_ready16), .res_data_o(res_data16),
    .busy_o(busy16)
  );

  // Advance one clock; inputs and samples sit 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int n);
    start   = 1'b1;
    num_ops = n[3:0];
    step();
    start   = 1'b0;
  endtask

  // Offer one operand until it is taken, bounded to 16 cycles.
  task automatic drive_op(input logic [15:0] d, output bit hs);
    op_valid = 1'b1;
    op_data  = d;
    hs       = 1'b0;
    for (int k = 0; k < 16 && !hs; k++) begin
      if (op_ready === 1'b1) hs = 1'b1;
      step();
    end
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if (op_ready !== 1'b0) $display("[TB] FAIL reset_op_ready: got %b expected 0", op_ready);
    else passed++;
    checks++;
    if (res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid);
    else passed++;
    checks++;
    if (res_data !== 24'h0) $display("[TB] FAIL reset_res_data: got %h expected 000000", res_data);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [15:0] ops[3] = '{16'd5, 16'd7, 16'd9};
    logic [23:0] exp;
    bit hs;
    exp_q.push_back(24'd21);
    start_job(3);
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL basic_busy_after_start: got %b expected 1", busy);
    else passed++;
    foreach (ops[i]) begin
      checks++;
      if (op_ready !== 1'b1) $display("[TB] FAIL basic_ready_%0d: got %b expected 1", i, op_ready);
      else passed++;
      drive_op(ops[i], hs);
    end
    op_valid = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL basic_resolve_cycle: got valid=%b busy=%b expected valid=0 busy=1", res_valid, busy);
    else passed++;
    step();
    exp = exp_q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp)
      $display("[TB] FAIL basic_result: got valid=%b data=%h expected valid=1 data=%h", res_valid, res_data, exp);
    else passed++;
    checks++;
    if (op_ready !== 1'b0) $display("[TB] FAIL basic_ready_in_done: got %b expected 0", op_ready);
    else passed++;
    step();
    checks++;
    if (busy !== 1'b1 || res_valid !== 1'b1)
      $display("[TB] FAIL basic_hold: got busy=%b valid=%b expected 1 1", busy, res_valid);
    else passed++;
    accept_result();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0)
      $display("[TB] FAIL basic_idle: got busy=%b valid=%b expected 0 0", busy, res_valid);
    else passed++;
  endtask

  task automatic test_gaps();
    logic [23:0] exp;
    bit hs;
    int gap;
    exp_q.push_back(24'h07FFF8);
    start_job(8);
    for (int i = 0; i < 8; i++) begin
      gap = $urandom_range(0, 3);
      op_valid = 1'b0;
      repeat (gap) step();
      checks++;
      if (u_dut.cnt_q !== 4'(8 - i))
        $display("[TB] FAIL gaps_cnt_%0d: got %0d expected %0d", i, u_dut.cnt_q, 8 - i);
      else passed++;
      drive_op(16'hFFFF, hs);
      checks++;
      if (!hs) $display("[TB] FAIL gaps_handshake_%0d: got none expected one", i);
      else passed++;
    end
    op_valid = 1'b0;
    step();
    exp = exp_q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp)
      $display("[TB] FAIL gaps_result: got valid=%b data=%h expected valid=1 data=%h", res_valid, res_data, exp);
    else passed++;
    accept_result();
  endtask

  task automatic test_modulo();
    int accepted = 0;
    logic [23:0] exp;
    start16   = 1'b1;
    num_ops16 = 4'd2;
    step();
    start16    = 1'b0;
    op_valid16 = 1'b1;
    op_data16  = 16'hFFFF;
    checks++;
    if (op_ready16 !== 1'b1) $display("[TB] FAIL mod16_ready: got %b expected 1", op_ready16);
    else passed++;
    step();
    op_data16 = 16'h0002;
    step();
    op_valid16 = 1'b0;
    step();
    checks++;
    if (res_valid16 !== 1'b1 || res_data16 !== 16'h0001)
      $display("[TB] FAIL mod16_result: got valid=%b data=%h expected valid=1 data=0001", res_valid16, res_data16);
    else passed++;
    res_ready16 = 1'b1;
    step();
    res_ready16 = 1'b0;

    exp_q.push_back(24'd36);
    start_job(12);
    op_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      op_data = 16'(i + 1);
      if (op_ready === 1'b1) accepted++;
      step();
    end
    op_valid = 1'b0;
    checks++;
    if (accepted != 8) $display("[TB] FAIL clamp_count: got %0d expected 8", accepted);
    else passed++;
    exp = exp_q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp)
      $display("[TB] FAIL clamp_result: got valid=%b data=%h expected valid=1 data=%h", res_valid, res_data, exp);
    else passed++;
    accept_result();
  endtask

  task automatic test_zero();
    logic [23:0] exp;
    exp_q.push_back(24'h0);
    start_job(0);
    checks++;
    if (op_ready !== 1'b0 || res_valid !== 1'b0)
      $display("[TB] FAIL zero_resolve: got ready=%b valid=%b expected 0 0", op_ready, res_valid);
    else passed++;
    step();
    exp = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp || op_ready !== 1'b0)
        $display("[TB] FAIL zero_hold_%0d: got valid=%b data=%h ready=%b expected 1 %h 0",
                 i, res_valid, res_data, op_ready, exp);
      else passed++;
      step();
    end
    accept_result();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0)
      $display("[TB] FAIL zero_idle: got busy=%b valid=%b expected 0 0", busy, res_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp;
    bit hs;
    exp_q.push_back(24'd30);
    start_job(2);
    start    = 1'b1;
    num_ops  = 4'd5;
    op_valid = 1'b1;
    op_data  = 16'd10;
    step();
    start = 1'b0;
    drive_op(16'd20, hs);
    op_valid = 1'b0;
    step();
    start   = 1'b1;
    num_ops = 4'd1;
    step();
    start = 1'b0;
    exp = exp_q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp)
      $display("[TB] FAIL ignore_start_result: got valid=%b data=%h expected valid=1 data=%h", res_valid, res_data, exp);
    else passed++;
    accept_result();

    exp_q.push_back(24'd100);
    start_job(1);
    checks++;
    if (op_ready !== 1'b1) $display("[TB] FAIL b2b_ready: got %b expected 1", op_ready);
    else passed++;
    drive_op(16'd100, hs);
    op_valid = 1'b0;
    step();
    exp = exp_q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp)
      $display("[TB] FAIL b2b_result: got valid=%b data=%h expected valid=1 data=%h", res_valid, res_data, exp);
    else passed++;
    accept_result();
  endtask

  task automatic test_reset_midjob();
    logic [15:0] ops[3] = '{16'd1, 16'd2, 16'd3};
    logic [23:0] exp;
    bit hs;
    start_job(4);
    drive_op(16'd1, hs);
    drive_op(16'd1, hs);
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 24'h0 || busy !== 1'b0)
      $display("[TB] FAIL async_reset: got ready=%b valid=%b data=%h busy=%b expected 0 0 000000 0",
               op_ready, res_valid, res_data, busy);
    else passed++;
    #2;
    rst_n = 1'b1;
    step();
    exp_q.push_back(24'd6);
    start_job(3);
    foreach (ops[i]) drive_op(ops[i], hs);
    op_valid = 1'b0;
    step();
    exp = exp_q.pop_front();
    checks++;
    if (res_valid !== 1'b1 || res_data !== exp)
      $display("[TB] FAIL after_reset_result: got valid=%b data=%h expected valid=1 data=%h", res_valid, res_data, exp);
    else passed++;
    accept_result();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    num_ops     = 4'd0;
    op_valid    = 1'b0;
    op_data     = 16'h0;
    res_ready   = 1'b0;
    start16     = 1'b0;
    num_ops16   = 4'd0;
    op_valid16  = 1'b0;
    op_data16   = 16'h0;
    res_ready16 = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_gaps();
    test_modulo();
    test_zero();
    test_back_to_back();
    test_reset_midjob();
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
